// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 encodings, M-extension funct7, FSM state type and small decode helpers.
package riscv_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } muldiv_state_t;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM (MULHSU keeps it unsigned)
    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the unsigned multiply/divide datapath.
// Multiply: {hi,lo} holds partial product over the remaining multiplier bits;
//           conditional add of m into hi, then shift {carry,hi,lo} right by one.
// Divide:   {hi,lo} holds partial remainder over the remaining dividend bits;
//           shift left by one, trial-subtract m, keep the difference if it does
//           not go negative and shift the quotient bit into lo.
module muldiv_iter_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] m,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Select add-shift or compare-subtract-shift for this iteration
    always_comb begin
        sum     = {1'b0, hi} + {1'b0, (lo[0] ? m : {XLEN{1'b0}})};
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, m};
        if (is_div) begin
            hi_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer beside the execute-stage ALU.
// Operands are reduced to magnitudes on accept, iterated unsigned, and the
// sign is restored on the final iteration.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies stop as soon as the remaining
// multiplier bits are zero, and multiply by zero takes the fast path.
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | one iteration per cycle, busy=1
// DONE  | one cycle, done=1, result valid; a new start may be accepted here
module alu_muldiv_sequencer
    import riscv_muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t   state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]      f3_q, f3_nxt;
    logic [XLEN-1:0] hi, hi_nxt, lo, lo_nxt, m, m_nxt;
    logic            neg, neg_nxt;
    logic [XLEN-1:0] result_q, result_nxt;

    logic [XLEN-1:0] st_hi, st_lo;
    logic            sa, sb, neg_in, fast, last;
    logic [XLEN-1:0] abs_a, abs_b, fast_val;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] mul_res, div_res, fin_res;

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .is_div (f3_is_div(f3_q)),
        .hi     (hi),
        .lo     (lo),
        .m      (m),
        .hi_nxt (st_hi),
        .lo_nxt (st_lo)
    );

    // Decode incoming request: magnitudes, result sign and fast-path result
    always_comb begin
        sa       = op_a[XLEN-1] & f3_a_signed(funct3);
        sb       = op_b[XLEN-1] & f3_b_signed(funct3);
        abs_a    = sa ? -op_a : op_a;
        abs_b    = sb ? -op_b : op_b;
        neg_in   = 1'b0;
        fast     = 1'b0;
        fast_val = '0;
        case (funct3)
            F3_MULH, F3_DIV:   neg_in = sa ^ sb;
            F3_MULHSU, F3_REM: neg_in = sa;
            default:           neg_in = 1'b0;
        endcase
        if (f3_is_div(funct3) && (op_b == '0)) begin
            fast     = 1'b1;
            fast_val = funct3[1] ? op_a : {XLEN{1'b1}};
        end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (op_a == MIN_NEG) && (&op_b)) begin
            fast     = 1'b1;
            fast_val = funct3[1] ? '0 : op_a;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!f3_is_div(funct3) && (op_b == '0)) begin
            fast     = 1'b1;
            fast_val = '0;
        end
`endif
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [CNT_W-1:0] iter_done;
    logic [CNT_W-1:0] align_sh;

    // Early exit: product sits left-aligned by the iterations not yet run
    always_comb begin
        iter_done = cnt + 1'b1;
        align_sh  = CNT_W'(XLEN) - iter_done;
        prod      = {st_hi, st_lo} >> align_sh;
        last      = (cnt == CNT_W'(XLEN-1)) ||
                    (!f3_is_div(f3_q) && ((st_lo << iter_done) == '0));
    end
`else
    // Fixed-length iteration: product is complete after XLEN steps
    always_comb begin
        prod = {st_hi, st_lo};
        last = (cnt == CNT_W'(XLEN-1));
    end
`endif

    // Sign fix-up of the final iteration's product, quotient or remainder
    always_comb begin
        prod_fix = neg ? -prod : prod;
        mul_res  = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        if (f3_q[1]) div_res = neg ? -st_hi : st_hi;
        else         div_res = neg ? -st_lo : st_lo;
        fin_res  = f3_is_div(f3_q) ? div_res : mul_res;
    end

    // Next-state and datapath load/iterate control
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        f3_nxt     = f3_q;
        hi_nxt     = hi;
        lo_nxt     = lo;
        m_nxt      = m;
        neg_nxt    = neg;
        result_nxt = result_q;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state_nxt = IDLE;
                    if (start) begin
                        f3_nxt  = funct3;
                        cnt_nxt = '0;
                        neg_nxt = neg_in;
                        hi_nxt  = '0;
                        lo_nxt  = f3_is_div(funct3) ? abs_a : abs_b;
                        m_nxt   = f3_is_div(funct3) ? abs_b : abs_a;
                        if (fast) begin
                            result_nxt = fast_val;
                            state_nxt  = DONE;
                        end else begin
                            state_nxt  = BUSY;
                        end
                    end
                end
                BUSY: begin
                    hi_nxt  = st_hi;
                    lo_nxt  = st_lo;
                    cnt_nxt = cnt + 1'b1;
                    if (last) begin
                        result_nxt = fin_res;
                        state_nxt  = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            f3_q     <= '0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            neg      <= 1'b0;
            result_q <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            f3_q     <= f3_nxt;
            hi       <= hi_nxt;
            lo       <= lo_nxt;
            m        <= m_nxt;
            neg      <= neg_nxt;
            result_q <= result_nxt;
        end
    end

    assign busy   = (state == BUSY);
    assign done   = (state == DONE) && !kill;
    assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Scoreboard bench for alu_muldiv_sequencer (XLEN=32). Stimulus pushes the
// expected result and completion edge; a negedge monitor pops on every done.
module tb_alu_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
        logic [2:0]  f3;
    } exp_t;

    exp_t sb_q[$];

    alu_muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      ps;
        logic [63:0] pu;
        int          da, db;
        da = $signed(a);
        db = $signed(b);
        case (f3)
            3'b000: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'b001: begin ps = longint'(da) * longint'(db); pu = ps; return pu[63:32]; end
            3'b010: begin ps = longint'(da) * longint'({32'b0, b}); pu = ps; return pu[63:32]; end
            3'b011: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return da / db;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return da % db;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from the sampling edge (counted as 1) to the edge that raises done
    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        int          hb;
        if (f3[2]) begin
            if (b == 0) return 1;
            if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_EARLY_OUT_EN
        mag = (f3 == 3'b001 && b[31]) ? -b : b;
        if (mag == 0) return 1;
        hb = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) hb = i;
        return hb + 2;
`else
        mag = a;
        hb  = mag[0];
        return 33 + hb - hb;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=1 result %h expected no done", result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_checks++;
                if (result !== e.res) begin
                    n_fail++;
                    $display("FAIL result f3=%0d: got %h expected %h", e.f3, result, e.res);
                end
                if (cyc != e.due) begin
                    n_fail++;
                    $display("FAIL done_edge f3=%0d: got edge %0d expected edge %0d", e.f3, cyc, e.due);
                end
            end
        end
    end

    // Drive a request; caller is just after a negedge or the previous sampling edge
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit push);
        int s;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
        if (push) sb_q.push_back('{res: model_res(f3, a, b), due: s + exp_lat(f3, a, b) - 1, f3: f3});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && busy === 1'b0) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL timeout: got %0d outstanding expected 0", sb_q.size());
        sb_q.delete();
    endtask

    task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        issue(f3, a, b, 1'b1);
        wait_idle();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 15);
            4: return -$urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          nb;
        bit          seen;
        logic [31:0] held;
        reset  = 1'b1;
        start  = 1'b0;
        kill   = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // MUL with latency and busy-length check
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1);
        nb   = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) seen = 1'b1;
        end
        check("mul_done_seen", {31'b0, seen}, 32'h1);
        check("mul_busy_cycles", nb, exp_lat(3'b000, 32'd7, 32'hFFFF_FFFD) - 1);
        wait_idle();

        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(3'b010, 32'hFFFF_FFFF, 32'd2);
        run(3'b100, 32'hFFFF_FFF9, 32'd2);
        run(3'b110, 32'hFFFF_FFF9, 32'd2);
        run(3'b101, 32'd100, 32'd7);
        run(3'b111, 32'd100, 32'd7);
        run(3'b101, 32'd5, 32'd0);
        run(3'b111, 32'd5, 32'd0);
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'b000, 32'd9, 32'd3);

        // start while BUSY is ignored
        issue(3'b000, 32'd3, 32'd5, 1'b1);
        @(negedge clk);
        issue(3'b101, 32'd100, 32'd7, 1'b0);
        wait_idle();
        check("after_ignored_start", result, 32'd15);

        // kill mid-operation: busy drops, no done, result held
        held = result;
        issue(3'b000, 32'd11, 32'd5, 1'b0);
`ifdef MULDIV_EARLY_OUT_EN
        @(negedge clk);
`else
        repeat (9) @(negedge clk);
`endif
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy", {31'b0, busy}, 32'h0);
        repeat (40) @(negedge clk);
        check("kill_result_held", result, held);
        run(3'b000, 32'd3, 32'd5);

        // reset mid-operation
        issue(3'b101, 32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_busy", {31'b0, busy}, 32'h0);
        check("midreset_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // back-to-back: fast path then accept in the DONE cycle
        issue(3'b101, 32'd5, 32'd0, 1'b1);
        issue(3'b000, 32'd9, 32'd3, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        issue(3'b100, 32'hFFFF_FF00, 32'd7, 1'b1);
        wait_idle();

        // randomized operations against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            run(3'($urandom_range(0, 7)), pick(), pick());
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
- Multi-cycle sequencer for RV32M multiply/divide instructions; sits beside the single-cycle ALU in the execute stage.
- Accepts operands and Funct3 when the main decoder flags an M-extension op (Funct7 = 0000001).
- Runs an iterative shift-add multiply or restoring divide, then returns the result with a done pulse.
- Hazard logic holds the pipeline while busy is high.

Parameters:
- XLEN, 32, operand/result width; must be even and ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request pulse; sampled only in IDLE or DONE
- kill  in  1  pipeline flush; aborts any operation in progress
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value (multiplicand/dividend)
- op_b  in  XLEN  rs2 value (multiplier/divisor)
- busy  out  1  high while an operation is running
- done  out  1  one-cycle pulse; result valid in that cycle
- result  out  XLEN  final value; held until the next accepted start

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, counter=0; internal accumulators cleared.
- States: IDLE, BUSY, DONE.
- IDLE/DONE + start & !kill: latch funct3 and operand magnitudes, record result sign, clear counter.
  - Normal case: go to BUSY.
  - Fast path: go to DONE directly.
- DONE lasts one cycle with done=1, then returns to IDLE unless a new start is accepted in that same cycle (back-to-back allowed).
- BUSY: one iteration per cycle; counter increments.
  - On counter = XLEN-1: apply sign fix-up, register result, go to DONE.
- Latency:
  - Normal: done rises exactly XLEN+1 edges after the edge that samples start.
  - Fast path: done rises 1 edge after that edge.
- busy=1 in BUSY only. The start-sampling cycle is combinationally reflected through busy_next for the stall; busy itself is registered.
- start while BUSY: ignored, with no effect on operands.
- kill:
  - In any state, go to IDLE next edge.
  - done is suppressed; result keeps its prior value.
  - kill has priority over start in the same cycle.
- Multiply:
  - Unsigned iteration on magnitudes into a 2·XLEN product register.
  - MULH and MULHSU negate the full product when the result sign is set.
  - MUL returns the low half; the H variants return the high half.
  - MULHSU treats op_b as unsigned.
- Divide:
  - Restoring algorithm on magnitudes.
  - Quotient is negated if the operand signs differ (DIV).
  - Remainder takes the dividend sign (REM).
- Fast path cases (no iteration):
  - Divisor = 0: DIV/DIVU return all-ones; REM/REMU return op_a.
  - Signed overflow (op_a = 1 followed by zeros, op_b = all-ones, DIV/REM): DIV returns op_a; REM returns 0.
- Multiply by zero is not a fast path unless the optional feature is enabled.
- Reset asserted mid-operation: immediate return to the reset state; no done.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in BUSY, multiply terminates when the remaining unshifted multiplier bits are all zero; fix-up and DONE follow on the next edge. Latency is (index of highest set bit of |op_b|) + 2 edges; op_b = 0 takes the fast path.
- Undefined: fixed XLEN-iteration latency for every non-fast-path operation. Division latency is unaffected either way.

Decomposition:
- Shared package riscv_muldiv_pkg:
  - funct3 localparams: F3_MUL … F3_REMU
  - state enum: muldiv_state_t {IDLE, BUSY, DONE}
  - M-extension Funct7 constant 7'b0000001
- Sub-module muldiv_iter_step: combinational single-iteration datapath (add-shift or compare-subtract-shift), selected by an is_div input.
- The sequencer keeps the FSM, counter, sign handling and registers.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD, macro undefined -> result=0xFFFFFFEB; done exactly 33 edges after start; busy high for 32 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU op_a=0xFFFFFFFF, op_b=2 -> 0xFFFFFFFF.
- DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, done 1 edge after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start MUL 3×5, assert kill on BUSY cycle 10 -> busy=0 next edge, no done, result unchanged. Start re-issued in BUSY is ignored. A fresh start afterwards -> 15.
- Back-to-back: new start during the DONE cycle -> second operation accepted, first done pulse still seen. With MULDIV_EARLY_OUT_EN, MUL 9×3 -> 27, done 3 edges after start.
